// File: rtl/cam_i2c_target.sv
// I2C target for the camera-config master: 7-bit address, 16-bit register pointer, 8-bit data.
// Optional read path (RDATA/MACK) is enabled by defining CAM_I2C_TGT_READ_EN.
module cam_i2c_target #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h36,
    parameter int unsigned FILT_LEN   = 3,
    parameter int unsigned HOLD_CYC   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        wr_en,
    output logic [15:0] reg_addr,
    output logic [7:0]  wr_data,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic [3:0]  dbg_state
);

`ifdef CAM_I2C_TGT_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam int HCW = $clog2(HOLD_CYC + 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ACK_ADDR  = 4'd2,
        REG_HI    = 4'd3,
        ACK_HI    = 4'd4,
        REG_LO    = 4'd5,
        ACK_LO    = 4'd6,
        WDATA     = 4'd7,
        ACK_WDATA = 4'd8,
        RDATA     = 4'd9,
        MACK      = 4'd10,
        IGNORE    = 4'd11
    } state_t;

    logic           r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic           r_scl_f, r_sda_f, r_scl_fd, r_sda_fd;
    logic [FCW-1:0] r_scl_cnt, r_sda_cnt;

    state_t         r_state;
    logic [7:0]     r_shift;
    logic [3:0]     r_bit_cnt;
    logic [7:0]     r_ptr_hi;
    logic           r_oe_pend;
    logic [HCW-1:0] r_hold_cnt;
    logic [6:0]     r_tx;
    logic           r_reload;
    logic           r_mack;

    logic           w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]     w_byte_in;

    assign dbg_state = r_state;

    // Lines idle high, so the synchronisers and filters come out of reset at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_s1  <= 1'b1;
            r_scl_s2  <= 1'b1;
            r_sda_s1  <= 1'b1;
            r_sda_s2  <= 1'b1;
            r_scl_f   <= 1'b1;
            r_sda_f   <= 1'b1;
            r_scl_fd  <= 1'b1;
            r_sda_fd  <= 1'b1;
            r_scl_cnt <= '0;
            r_sda_cnt <= '0;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
            r_scl_fd <= r_scl_f;
            r_sda_fd <= r_sda_f;
            if (r_scl_s2 == r_scl_f) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == FCW'(FILT_LEN - 1)) begin
                r_scl_f   <= r_scl_s2;
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 1'b1;
            end
            if (r_sda_s2 == r_sda_f) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == FCW'(FILT_LEN - 1)) begin
                r_sda_f   <= r_sda_s2;
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 1'b1;
            end
        end
    end

    assign w_scl_rise = r_scl_f & ~r_scl_fd;
    assign w_scl_fall = ~r_scl_f & r_scl_fd;
    assign w_start    = ~r_sda_f & r_sda_fd & r_scl_f & r_scl_fd;
    assign w_stop     = r_sda_f & ~r_sda_fd & r_scl_f & r_scl_fd;
    assign w_byte_in  = {r_shift[6:0], r_sda_f};

    // Every SCL fall schedules the next sda_oe value (r_oe_pend) to take effect HOLD_CYC clocks later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            sda_oe     <= 1'b0;
            wr_en      <= 1'b0;
            reg_addr   <= 16'h0000;
            wr_data    <= 8'h00;
            busy       <= 1'b0;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 4'd0;
            r_ptr_hi   <= 8'h00;
            r_oe_pend  <= 1'b0;
            r_hold_cnt <= '0;
            r_tx       <= 7'h00;
            r_reload   <= 1'b0;
            r_mack     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (wr_en) begin
                reg_addr <= reg_addr + 16'd1;
            end
            if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
                if (r_hold_cnt == HCW'(1)) begin
                    // Read byte fetched late so rd_data has settled on the updated pointer.
                    if (r_reload) begin
                        r_tx     <= rd_data[6:0];
                        sda_oe   <= ~rd_data[7];
                        r_reload <= 1'b0;
                    end else begin
                        sda_oe <= r_oe_pend;
                    end
                end
            end

            if (w_stop) begin
                r_state    <= IDLE;
                sda_oe     <= 1'b0;
                busy       <= 1'b0;
                r_oe_pend  <= 1'b0;
                r_hold_cnt <= '0;
                r_reload   <= 1'b0;
            end else if (w_start) begin
                r_state    <= ADDR;
                r_bit_cnt  <= 4'd0;
                sda_oe     <= 1'b0;
                r_oe_pend  <= 1'b0;
                r_hold_cnt <= '0;
                r_reload   <= 1'b0;
            end else if (w_scl_rise) begin
                case (r_state)
                    ADDR, REG_HI, REG_LO, WDATA: begin
                        r_shift   <= w_byte_in;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_state == WDATA && r_bit_cnt == 4'd7) begin
                            wr_en   <= 1'b1;
                            wr_data <= w_byte_in;
                        end
                    end
                    RDATA:   r_bit_cnt <= r_bit_cnt + 4'd1;
                    MACK:    r_mack <= ~r_sda_f;
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                r_hold_cnt <= HCW'(HOLD_CYC);
                case (r_state)
                    ADDR: if (r_bit_cnt == 4'd8) begin
                        r_bit_cnt <= 4'd0;
                        if (r_shift[7:1] == SLAVE_ADDR) begin
                            busy <= 1'b1;
                            if (r_shift[0] && !READ_EN) begin
                                r_state   <= IGNORE;
                                r_oe_pend <= 1'b0;
                            end else begin
                                r_state   <= ACK_ADDR;
                                r_oe_pend <= 1'b1;
                            end
                        end else begin
                            r_state   <= IGNORE;
                            r_oe_pend <= 1'b0;
                        end
                    end
                    ACK_ADDR: begin
                        r_oe_pend <= 1'b0;
                        if (r_shift[0]) begin
                            r_state  <= RDATA;
                            r_reload <= 1'b1;
                        end else begin
                            r_state <= REG_HI;
                        end
                    end
                    REG_HI: if (r_bit_cnt == 4'd8) begin
                        r_state   <= ACK_HI;
                        r_ptr_hi  <= r_shift;
                        r_oe_pend <= 1'b1;
                        r_bit_cnt <= 4'd0;
                    end
                    ACK_HI: begin
                        r_state   <= REG_LO;
                        r_oe_pend <= 1'b0;
                    end
                    REG_LO: if (r_bit_cnt == 4'd8) begin
                        r_state   <= ACK_LO;
                        reg_addr  <= {r_ptr_hi, r_shift};
                        r_oe_pend <= 1'b1;
                        r_bit_cnt <= 4'd0;
                    end
                    ACK_LO, ACK_WDATA: begin
                        r_state   <= WDATA;
                        r_oe_pend <= 1'b0;
                    end
                    WDATA: if (r_bit_cnt == 4'd8) begin
                        r_state   <= ACK_WDATA;
                        r_oe_pend <= 1'b1;
                        r_bit_cnt <= 4'd0;
                    end
                    RDATA: begin
                        if (r_bit_cnt == 4'd8) begin
                            r_state   <= MACK;
                            r_oe_pend <= 1'b0;
                            r_bit_cnt <= 4'd0;
                        end else begin
                            r_oe_pend <= ~r_tx[6];
                            r_tx      <= {r_tx[5:0], 1'b0};
                        end
                    end
                    // The pointer moves past every byte sent, whether the master ACKs or NACKs it.
                    MACK: begin
                        reg_addr  <= reg_addr + 16'd1;
                        r_oe_pend <= 1'b0;
                        if (r_mack) begin
                            r_state   <= RDATA;
                            r_reload  <= 1'b1;
                            r_bit_cnt <= 4'd0;
                        end else begin
                            r_state <= IGNORE;
                        end
                    end
                    default: r_oe_pend <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_i2c_target.sv
// Directed bench for cam_i2c_target: bit-banged I2C master, write scoreboard, hand-computed vectors.
// The read-path vector runs only when CAM_I2C_TGT_READ_EN is defined.
module tb_cam_i2c_target;

    localparam int Q = 100;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_REG_HI = 4'd3;
    localparam logic [3:0] ST_IGNORE = 4'd11;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl     = 1'b1;
    logic        m_sda   = 1'b1;
    logic        sda_bus;
    logic        sda_oe, wr_en, busy;
    logic [15:0] reg_addr;
    logic [7:0]  wr_data, rd_data;
    logic [3:0]  dbg_state;

    int          n_vec  = 0;
    int          n_err  = 0;
    int          wr_cnt = 0;
    logic        oe_seen = 1'b0;
    logic [23:0] exp_q[$];

    logic        ack;
    logic [7:0]  rbyte;
    int          wr_base;

    cam_i2c_target dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_in   (scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .wr_en    (wr_en),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h5A;
    endfunction

    assign sda_bus = m_sda & ~sda_oe;
    assign rd_data = mem_f(reg_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (sda_oe) oe_seen = 1'b1;
            if (wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) check("wr_unexpected", {8'h00, reg_addr, wr_data}, 32'hDEADBEEF);
                else check("wr_txn", {8'h00, reg_addr, wr_data}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    task automatic i2c_start();
        #(Q); m_sda = 1'b0;
        #(2*Q); scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        #(Q); m_sda = 1'b1;
        #(Q); scl = 1'b1;
        #(Q); m_sda = 1'b0;
        #(Q); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #(Q); m_sda = 1'b0;
        #(Q); scl = 1'b1;
        #(Q); m_sda = 1'b1;
        #(2*Q);
    endtask

    task automatic send_bit(input logic b);
        #(Q); m_sda = b;
        #(Q); scl = 1'b1;
        #(2*Q); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        #(Q); m_sda = 1'b1;
        #(Q); scl = 1'b1;
        #(Q); a = ~sda_bus;
        #(Q); scl = 1'b0;
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] b);
        b = 8'h00;
        #(Q); m_sda = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) #(Q);
            #(Q); scl = 1'b1;
            #(Q); b = {b[6:0], sda_bus};
            #(Q); scl = 1'b0;
        end
        #(Q); m_sda = ~m_ack;
        #(Q); scl = 1'b1;
        #(2*Q); scl = 1'b0;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_reg_addr", reg_addr, 16'h0000);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, ST_IDLE);
        reset_n = 1'b1;
        #(2*Q);

        // single write 0x0100 <- 0xA5
        wr_base = wr_cnt;
        exp_q.push_back({16'h0100, 8'hA5});
        i2c_start();
        write_byte(8'h6C, ack); check("t1_ack_addr", ack, 1);
        check("t1_busy", busy, 1);
        write_byte(8'h01, ack); check("t1_ack_hi", ack, 1);
        write_byte(8'h00, ack); check("t1_ack_lo", ack, 1);
        write_byte(8'hA5, ack); check("t1_ack_data", ack, 1);
        check("t1_wr_data", wr_data, 8'hA5);
        i2c_stop();
        check("t1_reg_addr", reg_addr, 16'h0101);
        check("t1_busy_stop", busy, 0);
        check("t1_wr_cnt", wr_cnt - wr_base, 1);

        // burst across the pointer wrap
        wr_base = wr_cnt;
        exp_q.push_back({16'hFFFF, 8'h11});
        exp_q.push_back({16'h0000, 8'h22});
        i2c_start();
        write_byte(8'h6C, ack); check("t2_ack_addr", ack, 1);
        write_byte(8'hFF, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h11, ack); check("t2_ack_d0", ack, 1);
        write_byte(8'h22, ack); check("t2_ack_d1", ack, 1);
        i2c_stop();
        check("t2_wr_cnt", wr_cnt - wr_base, 2);
        check("t2_reg_addr", reg_addr, 16'h0001);

        // STOP after only the high pointer byte leaves the pointer alone
        i2c_start();
        write_byte(8'h6C, ack);
        write_byte(8'hAB, ack); check("tp_ack_hi", ack, 1);
        i2c_stop();
        check("tp_reg_addr", reg_addr, 16'h0001);
        check("tp_state", dbg_state, ST_IDLE);

        // address mismatch: bus never driven, no writes, never busy
        wr_base = wr_cnt;
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'h50, ack); check("t3_nack_addr", ack, 0);
        check("t3_busy", busy, 0);
        write_byte(8'h01, ack);
        write_byte(8'h02, ack);
        write_byte(8'h03, ack); check("t3_nack_data", ack, 0);
        i2c_stop();
        check("t3_oe_seen", oe_seen, 0);
        check("t3_wr_cnt", wr_cnt - wr_base, 0);
        check("t3_busy_end", busy, 0);

`ifdef CAM_I2C_TGT_READ_EN
        // write pointer, repeated start, read two bytes
        i2c_start();
        write_byte(8'h6C, ack);
        write_byte(8'h30, ack);
        write_byte(8'h0A, ack); check("t4_ack_lo", ack, 1);
        i2c_rstart();
        write_byte(8'h6D, ack); check("t4_ack_rd", ack, 1);
        read_byte(1'b1, rbyte); check("t4_byte0", rbyte, 8'h60);
        read_byte(1'b0, rbyte); check("t4_byte1", rbyte, 8'h61);
        #(2*Q);
        check("t4_released", sda_oe, 0);
        i2c_stop();
        check("t4_reg_addr", reg_addr, 16'h300C);
`else
        // read request without the read path is refused
        i2c_start();
        write_byte(8'h6D, ack); check("t4_nack_rd", ack, 0);
        check("t4_state", dbg_state, ST_IGNORE);
        i2c_stop();
        check("t4_busy_end", busy, 0);
`endif

        // reset asserted while the target is holding the ACK low
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(8'h6C >> i);
        #(Q); m_sda = 1'b1;
        #(Q); scl = 1'b1;
        #(Q); check("t5_oe_before", sda_oe, 1);
        reset_n = 1'b0;
        #1;
        check("t5_oe_async", sda_oe, 0);
        check("t5_state", dbg_state, ST_IDLE);
        #(Q - 1); scl = 1'b0;
        #(Q); scl = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        #(2*Q);
        i2c_start();
        write_byte(8'h6C, ack); check("t5_ack_after", ack, 1);
        i2c_stop();

        // single-clock glitches
        m_sda = 1'b0; #10; m_sda = 1'b1;
        #(2*Q);
        check("t6_sda_glitch_state", dbg_state, ST_IDLE);
        check("t6_sda_glitch_busy", busy, 0);
        scl = 1'b0; #10; scl = 1'b1;
        #(2*Q);
        check("t6_scl_glitch_idle", dbg_state, ST_IDLE);
        exp_q.push_back({16'h2000, 8'h5A});
        i2c_start();
        write_byte(8'h6C, ack);
        #(2*Q);
        scl = 1'b1; #10; scl = 1'b0;
        #(2*Q);
        check("t6_scl_glitch_state", dbg_state, ST_REG_HI);
        write_byte(8'h20, ack);
        write_byte(8'h00, ack);
        write_byte(8'h5A, ack); check("t6_ack_data", ack, 1);
        i2c_stop();
        check("t6_reg_addr", reg_addr, 16'h2001);

        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
